// File: rtl/dff_mem_pkg.sv
// Shared types and widths for the DFF RAM arbiter and its arbiter sub-block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dff_mem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int N_REQ  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index of a requester (0 or 1).
    typedef logic req_idx_t;

    // One command as seen on a requester port.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // One-hot strobe for a requester index.
    function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dff_mem_arbiter_if.sv
// Requester-side command/response bundle for the two RAM requesters.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates acceptance; responses are strobes with no backpressure.
interface dff_mem_arbiter_if;
    import dff_mem_pkg::*;

    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic              req_we0;
    logic              req_we1;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [N_REQ-1:0]  rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    // Requester side.
    modport master (
        output req_valid, req_we0, req_we1, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_we0, req_we1, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-grant history register lives in the parent.
// Latency: purely combinational.
// Backpressure: en=0 suppresses every grant.
module rr_arb2
    import dff_mem_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         last_grant,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output req_idx_t         grant_idx
);

    // Lone requester wins; on contention the one not granted last time wins.
    always_comb begin
        grant     = '0;
        grant_idx = 1'b0;
        if (en) begin
            case (req)
                2'b01: begin
                    grant_idx = 1'b0;
                    grant     = idx_onehot(1'b0);
                end
                2'b10: begin
                    grant_idx = 1'b1;
                    grant     = idx_onehot(1'b1);
                end
                2'b11: begin
                    grant_idx = ~last_grant;
                    grant     = idx_onehot(~last_grant);
                end
                default: begin
                    grant     = '0;
                    grant_idx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dff_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one 64x8 single-port DFF RAM between two requesters.
// Latency: accept at N, mem_ce at N+1, read data from RAM at N+2, rsp_valid/rsp_data at N+3.
// Backpressure: req_ready only in IDLE with ena=1; one transaction per 3 cycles, responses unthrottled.
module dff_mem_arbiter
    import dff_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    dff_mem_arbiter_if.slave  bus,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t           state;
    state_t           state_nxt;
    req_idx_t         last_grant;
    req_idx_t         cur_idx;
    logic             cur_we;
    logic [N_REQ-1:0] grant;
    req_idx_t         grant_idx;
    logic             accept;
    cmd_t             sel_cmd;
    logic             mem_ce_nxt;
    logic             mem_we_nxt;
    logic [N_REQ-1:0] rsp_valid_nxt;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    // Grants are only offered while the RAM sequencer is idle.
    rr_arb2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .en         (ena && (state == IDLE)),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Steer the winning requester's command fields toward the latch.
    always_comb begin
        sel_cmd       = '0;
        sel_cmd.we    = grant_idx ? bus.req_we1    : bus.req_we0;
        sel_cmd.addr  = grant_idx ? bus.req_addr1  : bus.req_addr0;
        sel_cmd.wdata = grant_idx ? bus.req_wdata1 : bus.req_wdata0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the registered strobes.
    always_comb begin
        state_nxt     = state;
        mem_ce_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        rsp_valid_nxt = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = ISSUE;
                    mem_ce_nxt = 1'b1;
                    mem_we_nxt = sel_cmd.we;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt     = IDLE;
                rsp_valid_nxt = idx_onehot(cur_idx);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, RAM pin registers and response registers; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            cur_idx     <= 1'b0;
            cur_we      <= 1'b0;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            mem_ce      <= mem_ce_nxt;
            mem_we      <= mem_we_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            if (accept) begin
                last_grant <= grant_idx;
                cur_idx    <= grant_idx;
                cur_we     <= sel_cmd.we;
                mem_addr   <= sel_cmd.addr;
                mem_wdata  <= sel_cmd.wdata;
            end
            // Writes leave rsp_data holding the last read value.
            if ((state == RESP) && !cur_we) begin
                rsp_data_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Self-checking bench for dff_mem_arbiter with a behavioural 64x8 RAM and a response scoreboard.
// Latency: expects responses exactly three cycles after acceptance.
// Backpressure: requesters hold valid until req_ready, as the arbiter requires.
module tb_dff_mem_arbiter;
    import dff_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              vld0 = 1'b0;
    logic              vld1 = 1'b0;
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    dff_mem_arbiter_if bus ();
    assign bus.req_valid = {vld1, vld0};

    dff_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bus       (bus),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural single-port RAM: write at the edge, read data registered.
    logic [DATA_W-1:0] ram [64];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
        int                acc;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W-1:0] exp_last;
    int                grant_log[$];
    int                acc_log[$];
    int                checks = 0;
    int                errors = 0;

    function automatic void sb_push(input int i, input logic we, input logic [ADDR_W-1:0] a,
                                    input logic [DATA_W-1:0] d);
        exp_t e;
        if (we) ref_mem[a] = d;
        else    exp_last   = ref_mem[a];
        e.idx  = i;
        e.data = exp_last;
        e.acc  = cyc;
        sb.push_back(e);
        grant_log.push_back(i);
        acc_log.push_back(cyc);
    endfunction

    // Response monitor: every strobe must match the oldest accepted command.
    always @(negedge clk) begin
        if (cyc > 1 && bus.rsp_valid !== 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected rsp_valid=%b rsp_data=%h, no response outstanding",
                         bus.rsp_valid, bus.rsp_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rsp_valid !== idx_onehot(mon_e.idx[0]) || bus.rsp_data !== mon_e.data ||
                    cyc != mon_e.acc + 3) begin
                    errors++;
                    $display("FAIL rsp_match got valid=%b data=%h cyc=%0d, want valid=%b data=%h cyc=%0d",
                             bus.rsp_valid, bus.rsp_data, cyc, idx_onehot(mon_e.idx[0]),
                             mon_e.data, mon_e.acc + 3);
                end
            end
        end
    end

    // Present a command, wait for its acceptance, then optionally drop valid.
    task automatic issue(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit keep);
        bit done = 1'b0;
        if (i == 0) begin
            bus.req_we0 = we; bus.req_addr0 = a; bus.req_wdata0 = d; vld0 = 1'b1;
        end else begin
            bus.req_we1 = we; bus.req_addr1 = a; bus.req_wdata1 = d; vld1 = 1'b1;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready[i] === 1'b1) begin
                sb_push(i, we, a, d);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout req%0d got no req_ready, want one within 40 cycles", i);
        end
        @(posedge clk); #1;
        if (!keep) begin
            if (i == 0) vld0 = 1'b0;
            else        vld1 = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d outstanding responses, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
        sb.delete(); grant_log.delete(); acc_log.delete();
        exp_last = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp got ready=%b rsp_valid=%b rsp_data=%h, want 00 00 00",
                     bus.req_ready, bus.rsp_valid, bus.rsp_data);
        end
        checks++;
        if (mem_ce !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'h00 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mem got ce=%b we=%b addr=%h wdata=%h, want 0 0 00 00",
                     mem_ce, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int n;
        @(posedge clk); #1;
        issue(0, 1'b1, 6'h01, 8'hAA, 1'b0);
        n = acc_log[acc_log.size()-1];
        @(negedge clk);
        checks++;
        if (cyc != n + 1 || mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'h01 ||
            mem_wdata !== 8'hAA) begin
            errors++;
            $display("FAIL wr_issue got cyc=%0d ce=%b we=%b addr=%h wdata=%h, want cyc=%0d 1 1 01 aa",
                     cyc, mem_ce, mem_we, mem_addr, mem_wdata, n + 1);
        end
        @(negedge clk);
        checks++;
        if (mem_ce !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_one_cycle got ce=%b we=%b at N+2, want 0 0", mem_ce, mem_we);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL wr_rsp_time got rsp_valid=%b at N+3, want 01", bus.rsp_valid);
        end
        @(posedge clk); #1;
        issue(0, 1'b0, 6'h01, 8'h00, 1'b0);
        drain();
    endtask

    task automatic test_contention();
        int base = grant_log.size();
        @(posedge clk); #1;
        fork
            issue(0, 1'b1, 6'h05, 8'h11, 1'b0);
            issue(1, 1'b1, 6'h06, 8'h22, 1'b0);
        join
        checks++;
        if (grant_log[base] != 0 || grant_log[base+1] != 1 ||
            acc_log[base+1] - acc_log[base] != 3) begin
            errors++;
            $display("FAIL contention_order got grants %0d,%0d gap %0d, want 0,1 gap 3",
                     grant_log[base], grant_log[base+1], acc_log[base+1] - acc_log[base]);
        end
        fork
            issue(0, 1'b0, 6'h05, 8'h00, 1'b0);
            issue(1, 1'b0, 6'h06, 8'h00, 1'b0);
        join
        drain();
    endtask

    task automatic test_fairness();
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 4; k++) issue(0, 1'b1, 6'(8 + k), 8'(8'h30 + k), k < 3);
            end
            begin
                for (int m = 0; m < 4; m++) issue(1, 1'b1, 6'(16 + m), 8'(8'h40 + m), m < 3);
            end
        join
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant_log[k] != (k % 2) || (k > 0 && acc_log[k] - acc_log[k-1] != 3)) begin
                errors++;
                $display("FAIL fairness_%0d got grant %0d at cyc %0d, want grant %0d 3 cycles after prior",
                         k, grant_log[k], acc_log[k], k % 2);
            end
        end
        drain();
    endtask

    task automatic test_ena_gating();
        @(posedge clk); #1;
        ena = 1'b0;
        bus.req_we0 = 1'b1; bus.req_addr0 = 6'h20; bus.req_wdata0 = 8'h77; vld0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 2'b00 || mem_ce !== 1'b0) begin
                errors++;
                $display("FAIL ena_block got ready=%b ce=%b, want 00 0", bus.req_ready, mem_ce);
            end
        end
        @(posedge clk); #1 ena = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL ena_grant got ready=%b, want 01", bus.req_ready);
        end else begin
            sb_push(0, 1'b1, 6'h20, 8'h77);
        end
        // Dropping ena mid-transaction must still yield the response.
        @(posedge clk); #1;
        vld0 = 1'b0; ena = 1'b0;
        drain();
        ena = 1'b1;
        issue(1, 1'b0, 6'h20, 8'h00, 1'b0);
        drain();
    endtask

    task automatic test_boundary();
        @(posedge clk); #1;
        issue(0, 1'b1, 6'h00, 8'h5A, 1'b0);
        issue(0, 1'b1, 6'h3F, 8'hA5, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_addr !== 6'h3F || mem_wdata !== 8'hA5 || mem_ce !== 1'b1) begin
            errors++;
            $display("FAIL boundary_issue got addr=%h wdata=%h ce=%b, want 3f a5 1",
                     mem_addr, mem_wdata, mem_ce);
        end
        @(posedge clk); #1;
        issue(0, 1'b0, 6'h00, 8'h00, 1'b0);
        issue(1, 1'b0, 6'h3F, 8'h00, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk); #1;
        issue(0, 1'b0, 6'h05, 8'h00, 1'b0);
        // Now in the ISSUE cycle of the read.
        rst_n = 1'b0;
        sb.delete(); grant_log.delete(); acc_log.delete();
        exp_last = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_ce !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'h00 || mem_wdata !== 8'h00 ||
            bus.rsp_valid !== 2'b00 || bus.rsp_data !== 8'h00 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL midop_reset got ce=%b we=%b addr=%h wdata=%h rv=%b rd=%h rdy=%b, want all 0",
                     mem_ce, mem_we, mem_addr, mem_wdata, bus.rsp_valid, bus.rsp_data, bus.req_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        fork
            issue(1, 1'b1, 6'h2A, 8'hC3, 1'b0);
            issue(0, 1'b1, 6'h15, 8'h3C, 1'b0);
        join
        checks++;
        if (grant_log[0] != 0) begin
            errors++;
            $display("FAIL midop_first_grant got %0d, want 0", grant_log[0]);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no completion, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) begin
            ram[k]     = 8'h00;
            ref_mem[k] = 8'h00;
        end
        exp_last       = '0;
        rst_n          = 1'b0;
        ena            = 1'b1;
        bus.req_we0    = 1'b0; bus.req_we1    = 1'b0;
        bus.req_addr0  = '0;   bus.req_addr1  = '0;
        bus.req_wdata0 = '0;   bus.req_wdata1 = '0;

        test_reset();
        test_write_read();
        apply_reset();
        test_contention();
        apply_reset();
        test_fairness();
        test_ena_gating();
        test_boundary();
        test_reset_mid_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_mem_arbiter.md
# dff_mem_arbiter

Two-requester round-robin arbiter and sequencer for the 64 x 8 single-port DFF RAM. It accepts read and write commands over per-requester valid/ready handshakes and serialises them onto the RAM's address, chip-enable, write-enable and data pins. It returns read data and write acknowledgements on per-requester response strobes. It sits between the top-level pin decode and the RAM macro, so both the external pin interface and an internal test/scrub engine can share the one RAM.

## Interface
- ADDR_W, 6, RAM address width (64 words)
- DATA_W, 8, RAM data width
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  design enable; low blocks new grants, in-flight op completes
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester accept strobe (combinational, IDLE only)
- req_we0, req_we1  in  1 each  1 = write, 0 = read
- req_addr0, req_addr1  in  ADDR_W each  command address
- req_wdata0, req_wdata1  in  DATA_W each  write data
- rsp_valid  out  2  one-cycle response strobe to the granted requester
- rsp_data  out  DATA_W  read data, meaningful only with rsp_valid of a read
- mem_ce  out  1  RAM chip enable, active-high, registered
- mem_we  out  1  RAM write enable, active-high, registered
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_ce with mem_we=0

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: when ena=1 and any req_valid bit is high, pick the winner g and assert req_ready[g] in the same cycle. Latch g, we, addr and wdata. Go to ISSUE. With no request or ena=0: stay in IDLE and hold req_ready=0.
- ISSUE: drive mem_ce=1, mem_we=latched we, mem_addr, mem_wdata for exactly one cycle. Go to RESP.
- RESP: mem_ce=0 and mem_we=0. Capture mem_rdata into rsp_data for reads; rsp_data holds its previous value for writes. Set rsp_valid[g] for the next cycle. Go to IDLE.
- Arbitration is round-robin with a last_grant register.
  - Single requester valid: that requester wins.
  - Both valid: the requester other than last_grant wins.
  - last_grant updates only on acceptance.
  - Reset value last_grant=1, so requester 0 wins the first contention.
- Requesters hold valid and command fields stable until req_ready. Fields are ignored after acceptance.
- A request deasserted before acceptance is dropped silently.
- Simultaneous events:
  - rsp_valid of one transaction coincides with IDLE, so a new grant may occur in that same cycle.
  - A requester may re-request immediately after receiving rsp_valid.
- ena falling mid-transaction does not abort; the transaction completes and returns its response.
- Address wrap is not applicable; addresses are used verbatim, all 64 valid.
- Reset, including mid-operation: FSM=IDLE, any in-flight transaction is abandoned with no response, last_grant=1.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Accept at cycle N.
- mem_ce high in cycle N+1.
- RAM read data valid in N+2.
- rsp_valid and rsp_data in N+3, for both reads and writes.
- Throughput: one transaction per 3 cycles. The next accept can be at N+3.
- The only combinational path is req_valid/ena -> req_ready. All other outputs are registered.
- Read-after-write to the same address returns the new data. This holds because the write completes at N+1, before the earliest next issue at N+4.

## Structure
- Shared package `dff_mem_pkg`: ADDR_W, DATA_W, FSM state enum (IDLE/ISSUE/RESP), requester-index type.
- One sub-module, `rr_arb2`: 2-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, en.
  - Outputs: grant one-hot, grant index.
  - Purely combinational.
  - The last_grant register stays in the parent.
- The RAM itself is not instantiated inside; the top level connects mem_* to the RAM.

## Test plan
- Single write then read: req0 writes 0xAA at address 0x01, then reads 0x01. Required: req_ready[0] on accept cycle, mem_ce/mem_we=1 exactly at N+1, rsp_valid[0] at N+3, read rsp_data=0xAA.
- Contention: both requesters valid in the same cycle after reset; req0 writes 0x11@0x05, req1 writes 0x22@0x06. Required: req0 granted first, req1 granted at N+3, reads return 0x11 and 0x22.
- Fairness: both hold valid continuously for 8 transactions. Required: grants alternate 0,1,0,1,… and no requester waits more than 3 cycles beyond the other's response.
- ena gating: ena=0 with req_valid=2'b01. Required: req_ready stays 0 and mem_ce stays 0. Then raise ena; grant occurs the same cycle.
- Reset mid-op: assert rst_n=0 in the ISSUE cycle of a read. Required: next cycle all outputs 0, no rsp_valid, and the first post-reset contention is won by req0.
- Boundary addresses: write 0x5A@0x00 and 0xA5@0x3F, read both back. Required: 0x5A and 0xA5 respectively, no aliasing.
